tlc_sensor: RTL and testbench
=============================

// Module: tlc_sensor
// PURPOSE
//  Vehicle-detection front end for the two-street traffic light controller. It debounces
//  the raw inductive-loop inputs of street A and street B and counts queued vehicles per
//  street. It drives the controller's traffic inputs ta/tb. It reads back the green lamps
//  ga/gb to retire queued vehicles as they drain on green.
// PARAMETERS
//  DEB_CYC  3  consecutive sampled edges a raw loop level must differ before debounced level flips
//  CNT_W    4  width of each queue counter (max queue 2**CNT_W-1)
//  DEP_CYC  4  consecutive green cycles per departing vehicle
// PORTS
//  clk     in   1      rising-edge clock
//  r       in   1      reset, synchronous, active-low (sampled on posedge clk)
//  loop_a  in   1      raw loop detector, street A (may glitch)
//  loop_b  in   1      raw loop detector, street B
//  ga      in   1      green lamp A from controller
//  gb      in   1      green lamp B from controller
//  ta      out  1      traffic present on A, to controller
//  tb      out  1      traffic present on B, to controller
//  qa      out  CNT_W  vehicles queued on A
//  qb      out  CNT_W  vehicles queued on B
//  ovf_a   out  1      sticky: arrival lost on A (queue full)
//  ovf_b   out  1      sticky: arrival lost on B
// BEHAVIOUR
//  Channels A and B are identical and independent; described for A.
//  Reset: any posedge clk with r=0 clears da, debounce count, qa, departure timer and ovf_a.
//   Then ta=0. Reset overrides all other activity, including mid-debounce and mid-departure.
//  Debounce: da is a registered level. Counter dc increments on each edge where loop_a!=da.
//   An edge with loop_a==da clears dc. On the DEB_CYC-th consecutive differing edge, da takes
//   loop_a and dc clears.
//  Arrival: fires on the same edge da goes 0->1 (one per clean pulse).
//   da 1->0 has no queue effect.
//  Departure timer dt (0..DEP_CYC-1):
//   - dt increments on each edge with ga=1 and qa!=0.
//   - On the edge where dt==DEP_CYC-1, a departure fires and dt reloads to 0.
//   - dt clears on any edge with ga=0 or qa==0. An interrupted green loses partial progress.
//  Queue update on each edge:
//   - arrival only: qa+1.
//   - departure only: qa-1.
//   - both: qa unchanged.
//   - neither: hold.
//  Full: an arrival alone with qa==2**CNT_W-1 leaves qa saturated and sets ovf_a. ovf_a holds
//   until reset. Arrival+departure at full is the "both" case: qa unchanged, no overflow.
//  Empty: no departure can fire at qa==0, so the counter never wraps below 0.
//  ta = da | (qa!=0). This is combinational from registers: ta rises on the same edge as the
//   debounced arrival, with no extra latency.
//  ga and gb both high (illegal from the controller): each channel drains independently.
//   No error is flagged.
// TESTING
//  1 r=0 for 2 edges with loop_a=loop_b=1 -> qa=qb=0, ta=tb=0, ovf=0. Release r.
//    -> qa=1 and ta=1 on the 3rd edge after release.
//  2 loop_a high for 2 edges then low -> da never rises, qa=0, ta=0 throughout.
//  3 loop_a high 5 edges, low 4, ga=0 -> qa=1, ta=1 at the 3rd edge. ta stays 1 after da falls.
//    Then ga=1 for 4 edges -> qa=0 and ta=0 after the 4th.
//  4 CNT_W=4, gb=0, 16 clean pulses on loop_b -> qb=15 after the 15th, ovf_b=0. The 16th
//    pulse -> qb=15, ovf_b=1. ovf_b stays 1 until r=0, which clears qb and ovf_b.
//  5 qa=2, ga=1, arrival edge coincides with 4th green edge -> qa=2, dt=0. Next 4 edges
//    drain to qa=1.
//  6 qa=3: ga high 3 edges, low 1, high 3 -> qa=3 (no departure). Assert r=0 mid-green
//    -> qa=0, ta=0 next edge.

Source files
------------

// File: rtl/tlc_sensor.sv
// Vehicle-detection front end: debounces raw loop detectors, keeps a per-street queue count,
// and drains the queue while the street's green lamp is on.

module tlc_sensor_chan #(
  parameter int unsigned DEB_CYC = 3,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned DEP_CYC = 4
) (
  input  logic             clk,
  input  logic             r,
  input  logic             loop_i,
  input  logic             green_i,
  output logic             t_o,
  output logic [CNT_W-1:0] q_o,
  output logic             ovf_o
);

  localparam int unsigned DC_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int unsigned DT_W = (DEP_CYC > 1) ? $clog2(DEP_CYC) : 1;
  localparam logic [DC_W-1:0]  DC_LAST = DC_W'(DEB_CYC - 1);
  localparam logic [DT_W-1:0]  DT_LAST = DT_W'(DEP_CYC - 1);
  localparam logic [CNT_W-1:0] Q_MAX   = '1;

  logic             da_q, da_d;
  logic [DC_W-1:0]  dc_q, dc_d;
  logic [DT_W-1:0]  dt_q, dt_d;
  logic [CNT_W-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             arrival;
  logic             depart;

  // Debounce, departure timer and queue update for one street.
  always_comb begin
    da_d    = da_q;
    dc_d    = '0;
    dt_d    = '0;
    q_d     = q_q;
    ovf_d   = ovf_q;
    arrival = 1'b0;
    depart  = 1'b0;

    if (loop_i != da_q) begin
      if (dc_q == DC_LAST) begin
        da_d    = loop_i;
        arrival = loop_i;
      end else begin
        dc_d = dc_q + DC_W'(1);
      end
    end

    // Any green gap or empty queue throws away partial departure progress.
    if (green_i && (q_q != '0)) begin
      if (dt_q == DT_LAST) begin
        depart = 1'b1;
      end else begin
        dt_d = dt_q + DT_W'(1);
      end
    end

    case ({arrival, depart})
      2'b10: begin
        if (q_q == Q_MAX) begin
          ovf_d = 1'b1;
        end else begin
          q_d = q_q + CNT_W'(1);
        end
      end
      2'b01:   q_d = q_q - CNT_W'(1);
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!r) begin
      da_q  <= 1'b0;
      dc_q  <= '0;
      dt_q  <= '0;
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      da_q  <= da_d;
      dc_q  <= dc_d;
      dt_q  <= dt_d;
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  // Decoded straight from registers so traffic shows on the arrival edge itself.
  assign t_o   = da_q | (q_q != '0);
  assign q_o   = q_q;
  assign ovf_o = ovf_q;

endmodule

module tlc_sensor #(
  parameter int unsigned DEB_CYC = 3,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned DEP_CYC = 4
) (
  input  logic             clk,
  input  logic             r,
  input  logic             loop_a,
  input  logic             loop_b,
  input  logic             ga,
  input  logic             gb,
  output logic             ta,
  output logic             tb,
  output logic [CNT_W-1:0] qa,
  output logic [CNT_W-1:0] qb,
  output logic             ovf_a,
  output logic             ovf_b
);

  tlc_sensor_chan #(
    .DEB_CYC (DEB_CYC),
    .CNT_W   (CNT_W),
    .DEP_CYC (DEP_CYC)
  ) u_chan_a (
    .clk     (clk),
    .r       (r),
    .loop_i  (loop_a),
    .green_i (ga),
    .t_o     (ta),
    .q_o     (qa),
    .ovf_o   (ovf_a)
  );

  tlc_sensor_chan #(
    .DEB_CYC (DEB_CYC),
    .CNT_W   (CNT_W),
    .DEP_CYC (DEP_CYC)
  ) u_chan_b (
    .clk     (clk),
    .r       (r),
    .loop_i  (loop_b),
    .green_i (gb),
    .t_o     (tb),
    .q_o     (qb),
    .ovf_o   (ovf_b)
  );

endmodule

// File: tb/tb_tlc_sensor.sv
// Directed bench for tlc_sensor: a per-edge vector table plus hand-written multi-cycle sequences.

module tb_tlc_sensor;

  logic       clk = 1'b0;
  logic       r = 1'b0;
  logic       loop_a = 1'b0;
  logic       loop_b = 1'b0;
  logic       ga = 1'b0;
  logic       gb = 1'b0;
  logic       ta, tb;
  logic [3:0] qa, qb;
  logic       ovf_a, ovf_b;

  int checks = 0;
  int failures = 0;

  tlc_sensor #(.DEB_CYC(3), .CNT_W(4), .DEP_CYC(4)) dut (
    .clk    (clk),
    .r      (r),
    .loop_a (loop_a),
    .loop_b (loop_b),
    .ga     (ga),
    .gb     (gb),
    .ta     (ta),
    .tb     (tb),
    .qa     (qa),
    .qb     (qb),
    .ovf_a  (ovf_a),
    .ovf_b  (ovf_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, la, lb, ga, gb;
    logic       ta, tb;
    logic [3:0] qa, qb;
    logic       oa, ob;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r_v, logic la, logic lb, logic ga_v, logic gb_v,
                              logic eta, logic etb, logic [3:0] eqa, logic [3:0] eqb,
                              logic eoa, logic eob);
    vec_t v;
    v.r = r_v; v.la = la; v.lb = lb; v.ga = ga_v; v.gb = gb_v;
    v.ta = eta; v.tb = etb; v.qa = eqa; v.qb = eqb; v.oa = eoa; v.ob = eob;
    return v;
  endfunction

  // Apply inputs away from the edge, clock once, then sample 1 ns after the edge.
  task automatic step(input logic r_v, input logic la, input logic lb,
                      input logic ga_v, input logic gb_v);
    r = r_v; loop_a = la; loop_b = lb; ga = ga_v; gb = gb_v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clean detector pulse: high 3 edges, low 3 edges, lamps held as given.
  task automatic pulse(input logic on_a, input logic ga_v, input logic gb_v);
    for (int i = 0; i < 3; i++) step(1'b1, on_a, ~on_a, ga_v, gb_v);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, ga_v, gb_v);
  endtask

  initial begin
    // Reset with loops high, glitch rejection, arrival, debounced fall, drain on green.
    vecs.push_back(mk(0,1,1,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(1,1,1,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(1,1,1,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(1,1,1,0,0, 1,1,1,1,0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0, 1,0,1,0,0,0));
    vecs.push_back(mk(1,1,0,0,0, 1,0,1,0,0,0));
    vecs.push_back(mk(1,1,0,0,0, 1,0,1,0,0,0));
    vecs.push_back(mk(1,0,0,0,0, 1,0,1,0,0,0));
    vecs.push_back(mk(1,0,0,0,0, 1,0,1,0,0,0));
    vecs.push_back(mk(1,0,0,0,0, 1,0,1,0,0,0));
    vecs.push_back(mk(1,0,0,0,0, 1,0,1,0,0,0));
    vecs.push_back(mk(1,0,0,1,0, 1,0,1,0,0,0));
    vecs.push_back(mk(1,0,0,1,0, 1,0,1,0,0,0));
    vecs.push_back(mk(1,0,0,1,0, 1,0,1,0,0,0));
    vecs.push_back(mk(1,0,0,1,0, 0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,1,0, 0,0,0,0,0,0));

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].la, vecs[i].lb, vecs[i].ga, vecs[i].gb);
      chk($sformatf("vec%0d", i),
          16'({ta, tb, qa, qb, ovf_a, ovf_b}),
          16'({vecs[i].ta, vecs[i].tb, vecs[i].qa, vecs[i].qb, vecs[i].oa, vecs[i].ob}));
    end

    // Fill street B to saturation, then overflow, sticky until reset.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int p = 1; p <= 16; p++) begin
      pulse(1'b0, 1'b0, 1'b0);
      if (p >= 14) begin
        chk($sformatf("fill_qb_p%0d", p), 16'(qb), 16'((p > 15) ? 15 : p));
        chk($sformatf("fill_ovf_b_p%0d", p), 16'(ovf_b), 16'(p > 15));
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_b_sticky", 16'({ovf_b, tb, qb}), 16'({1'b1, 1'b1, 4'd15}));
    chk("ovf_a_clear", 16'(ovf_a), 16'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_b_reset", 16'({ovf_b, tb, qb}), 16'd0);

    // Arrival lands on the same edge as a departure: queue holds, timer restarts.
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("qa_two", 16'(qa), 16'd2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("arr_dep_same_edge", 16'({ta, qa}), 16'({1'b1, 4'd2}));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("post_coincide_3", 16'(qa), 16'd2);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("post_coincide_4", 16'(qa), 16'd1);

    // Interrupted green loses progress; reset mid-green clears everything.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b0);
    chk("qa_three", 16'(qa), 16'd3);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("green_gap_no_dep", 16'(qa), 16'd3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("reset_mid_green", 16'({ta, qa, ovf_a}), 16'd0);

    // Both lamps green: each street drains on its own.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0);
    chk("both_queued", 16'({qa, qb}), 16'({4'd1, 4'd1}));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("both_green_3", 16'({qa, qb}), 16'({4'd1, 4'd1}));
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("both_green_4", 16'({ta, tb, qa, qb}), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
